// File: rtl/uart_rx_framer.sv
// ---------------------------------------------------------------------------
// uart_rx_framer
//   Receives asynchronous serial frames. Each frame has a start bit,
//   pDATA_BITS data bits sent LSB-first, an optional parity bit and a stop
//   bit. The line is oversampled at 16x the baud rate. Each bit value is the
//   majority vote of samples 7, 8 and 9.
//
// Parameters
//   pDATA_BITS  : data bits per frame (5..8)
//   pPARITY_EN  : 1 = a parity bit follows the data bits
//   pPARITY_ODD : 0 = even parity, 1 = odd parity (ignored without parity)
//
// Ports
//   sys_clk     : system clock, rising-edge active
//   rst_n       : asynchronous active-low reset
//   sample_tick : one-cycle strobe at 16x baud
//   rx          : raw serial line, idles high
//   rx_data     : last received byte, zero-extended above pDATA_BITS-1
//   rx_valid    : one-cycle pulse when a frame completes
//   frame_err   : stop bit of the last frame was sampled low
//   parity_err  : parity mismatch in the last frame
// ---------------------------------------------------------------------------
module uart_rx_framer #(
    parameter int pDATA_BITS  = 8,
    parameter int pPARITY_EN  = 0,
    parameter int pPARITY_ODD = 0
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       sample_tick,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int         DW       = pDATA_BITS;
    localparam logic [2:0] LAST_BIT = 3'(pDATA_BITS - 1);
    localparam logic       PAR_ODD  = (pPARITY_ODD != 0);
    localparam logic       PAR_EN   = (pPARITY_EN != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state, state_n;
    logic [1:0]      sync_q;
    logic            srx;
    logic [3:0]      cnt, cnt_n;
    logic [2:0]      bidx, bidx_n;
    logic [DW-1:0]   shreg, shreg_n;
    logic            par, par_n;
    logic            s7, s7_n, s8, s8_n;
    logic            perr_q, perr_q_n;
    logic            vote;
    logic [7:0]      data_ext;
    logic [7:0]      rx_data_n;
    logic            rx_valid_n, frame_err_n, parity_err_n;

    // Two-flop synchronizer; resets to the idle level so a reset never
    // looks like a start edge.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign srx = sync_q[1];

    // State register for the framer and its registered outputs.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            bidx       <= 3'd0;
            shreg      <= '0;
            par        <= 1'b0;
            s7         <= 1'b0;
            s8         <= 1'b0;
            perr_q     <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bidx       <= bidx_n;
            shreg      <= shreg_n;
            par        <= par_n;
            s7         <= s7_n;
            s8         <= s8_n;
            perr_q     <= perr_q_n;
            rx_data    <= rx_data_n;
            rx_valid   <= rx_valid_n;
            frame_err  <= frame_err_n;
            parity_err <= parity_err_n;
        end
    end

    // Next-state logic. Everything holds between ticks. Outside IDLE the
    // sample counter free-runs 0..15 per bit: mid-bit (cnt=9) is where the
    // vote is taken, and the 15->0 wrap is where the bit boundary falls.
    // STOP leaves at mid-bit so the next start edge can be caught early.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        bidx_n       = bidx;
        shreg_n      = shreg;
        par_n        = par;
        s7_n         = s7;
        s8_n         = s8;
        perr_q_n     = perr_q;
        rx_data_n    = rx_data;
        rx_valid_n   = 1'b0;
        frame_err_n  = frame_err;
        parity_err_n = parity_err;

        vote = (s7 & s8) | (s7 & srx) | (s8 & srx);

        data_ext         = 8'h00;
        data_ext[DW-1:0] = shreg;

        if (sample_tick) begin
            if (state == IDLE) begin
                if (!srx) begin
                    state_n  = START;
                    cnt_n    = 4'd1;
                    par_n    = 1'b0;
                    perr_q_n = 1'b0;
                end
            end else begin
                cnt_n = cnt + 4'd1;
                if (cnt == 4'd7) s7_n = srx;
                if (cnt == 4'd8) s8_n = srx;

                case (state)
                    START: begin
                        if (cnt == 4'd9 && vote) begin
                            state_n = IDLE;
                            cnt_n   = 4'd0;
                        end else if (cnt == 4'd15) begin
                            state_n = DATA;
                            bidx_n  = 3'd0;
                        end
                    end
                    DATA: begin
                        if (cnt == 4'd9) begin
                            shreg_n = {vote, shreg[DW-1:1]};
                            par_n   = par ^ vote;
                        end else if (cnt == 4'd15) begin
                            if (bidx == LAST_BIT) begin
                                state_n = PAR_EN ? PARITY : STOP;
                            end else begin
                                bidx_n = bidx + 3'd1;
                            end
                        end
                    end
                    PARITY: begin
                        if (cnt == 4'd9) begin
                            perr_q_n = (par ^ PAR_ODD) != vote;
                        end else if (cnt == 4'd15) begin
                            state_n = STOP;
                        end
                    end
                    STOP: begin
                        if (cnt == 4'd9) begin
                            rx_data_n    = data_ext;
                            frame_err_n  = ~vote;
                            parity_err_n = PAR_EN & perr_q;
                            rx_valid_n   = 1'b1;
                            state_n      = IDLE;
                            cnt_n        = 4'd0;
                        end
                    end
                    default: begin
                        state_n = IDLE;
                        cnt_n   = 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_framer
//   Self-checking bench for uart_rx_framer. Two instances share the clock,
//   tick strobe and reset: dut_a uses default parameters, dut_b has even
//   parity enabled. Each has its own serial line. Frames are serialised
//   tick by tick. Every frame pushes its expected result into a per-DUT
//   queue, and a monitor pops and compares on each rx_valid.
// ---------------------------------------------------------------------------
module tb_uart_rx_framer;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       sys_clk;
    logic       rst_n;
    logic       sample_tick;
    logic       rx;
    logic       rx_p;
    logic [7:0] rx_data,  rx_data_p;
    logic       rx_valid, rx_valid_p;
    logic       frame_err, frame_err_p;
    logic       parity_err, parity_err_p;

    int   vectors    = 0;
    int   miscompares = 0;
    exp_t exp_a[$];
    exp_t exp_b[$];

    uart_rx_framer dut_a (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .parity_err  (parity_err)
    );

    uart_rx_framer #(
        .pDATA_BITS  (8),
        .pPARITY_EN  (1),
        .pPARITY_ODD (0)
    ) dut_b (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .rx          (rx_p),
        .rx_data     (rx_data_p),
        .rx_valid    (rx_valid_p),
        .frame_err   (frame_err_p),
        .parity_err  (parity_err_p)
    );

    // 100 MHz-style clock.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // One-cycle tick every 4 clocks, changed on the falling edge.
    initial begin
        sample_tick = 1'b0;
        forever begin
            repeat (3) @(negedge sys_clk);
            sample_tick = 1'b1;
            @(negedge sys_clk);
            sample_tick = 1'b0;
        end
    end

    task automatic check_output(input string tag, input logic [7:0] observed,
                                input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, observed, expected);
        end
    endtask

    // Returns 1 ns after the rising edge on which sample_tick was high.
    task automatic wait_tick();
        for (int i = 0; i < 16; i++) begin
            @(posedge sys_clk);
            if (sample_tick) break;
        end
        #1;
    endtask

    task automatic set_line(input int line, input logic v);
        if (line == 0) rx = v;
        else           rx_p = v;
    endtask

    // One bit time. Level k is what the DUT samples at cnt=k because the
    // two-flop synchronizer settles well inside the 4-clock tick spacing.
    task automatic send_bit(input int line, input logic v, input logic inv8,
                            input logic release_late);
        logic lvl;
        for (int k = 0; k < 16; k++) begin
            lvl = v;
            if (inv8 && k == 8) lvl = ~v;
            if (release_late && k > 9) lvl = 1'b1;
            set_line(line, lvl);
            wait_tick();
        end
    endtask

    task automatic idle_ticks(input int n);
        rx   = 1'b1;
        rx_p = 1'b1;
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    task automatic apply_stimulus(input int line, input logic [7:0] data,
                                  input logic par_en, input logic par_bit,
                                  input logic stop_bit, input logic inv8);
        exp_t e;
        e.data = data;
        e.ferr = ~stop_bit;
        e.perr = par_en ? ((^data) != par_bit) : 1'b0;
        if (line == 0) exp_a.push_back(e);
        else           exp_b.push_back(e);
        wait_tick();
        send_bit(line, 1'b0, inv8, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(line, data[i], inv8, 1'b0);
        if (par_en) send_bit(line, par_bit, inv8, 1'b0);
        send_bit(line, stop_bit, inv8, 1'b1);
        set_line(line, 1'b1);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 400) begin
            @(negedge sys_clk);
            n++;
        end
        check_output(tag, 8'(exp_a.size() + exp_b.size()), 8'h00);
        exp_a.delete();
        exp_b.delete();
    endtask

    task automatic monitor_a();
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (rx_valid === 1'b1) begin
                check_output("valid_width_a", {7'b0, prev}, 8'h00);
                if (exp_a.size() == 0) begin
                    check_output("spurious_valid_a", {7'b0, rx_valid}, 8'h00);
                end else begin
                    e = exp_a.pop_front();
                    check_output("rx_data_a", rx_data, e.data);
                    check_output("frame_err_a", {7'b0, frame_err}, {7'b0, e.ferr});
                    check_output("parity_err_a", {7'b0, parity_err}, {7'b0, e.perr});
                end
            end
            prev = rx_valid;
        end
    endtask

    task automatic monitor_b();
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (rx_valid_p === 1'b1) begin
                check_output("valid_width_b", {7'b0, prev}, 8'h00);
                if (exp_b.size() == 0) begin
                    check_output("spurious_valid_b", {7'b0, rx_valid_p}, 8'h00);
                end else begin
                    e = exp_b.pop_front();
                    check_output("rx_data_b", rx_data_p, e.data);
                    check_output("frame_err_b", {7'b0, frame_err_p}, {7'b0, e.ferr});
                    check_output("parity_err_b", {7'b0, parity_err_p}, {7'b0, e.perr});
                end
            end
            prev = rx_valid_p;
        end
    endtask

    initial begin
        rx    = 1'b1;
        rx_p  = 1'b1;
        rst_n = 1'b0;

        fork
            monitor_a();
            monitor_b();
        join_none

        // Reset state, checked before the first clock edge.
        #3;
        check_output("reset_rx_data", rx_data, 8'h00);
        check_output("reset_rx_valid", {7'b0, rx_valid}, 8'h00);
        check_output("reset_frame_err", {7'b0, frame_err}, 8'h00);
        check_output("reset_parity_err", {7'b0, parity_err_p}, 8'h00);
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        idle_ticks(20);

        // Clean frame.
        apply_stimulus(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_drain("pending_a5");
        idle_ticks(20);

        // False start: three low ticks, then high.
        wait_tick();
        for (int k = 0; k < 3; k++) begin
            rx = 1'b0;
            wait_tick();
        end
        rx = 1'b1;
        idle_ticks(40);
        apply_stimulus(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_drain("pending_3c");
        idle_ticks(20);

        // Stop bit low, then outputs must hold, then a clean frame clears it.
        apply_stimulus(0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_drain("pending_81");
        repeat (50) @(negedge sys_clk);
        check_output("hold_rx_data", rx_data, 8'h81);
        check_output("hold_frame_err", {7'b0, frame_err}, 8'h01);
        idle_ticks(20);
        apply_stimulus(0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_drain("pending_5a");
        idle_ticks(20);

        // Even parity: 0x07 has odd weight, so the correct parity bit is 1.
        apply_stimulus(1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_drain("pending_07_bad");
        idle_ticks(20);
        apply_stimulus(1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_drain("pending_07_good");
        idle_ticks(20);

        // Sample 8 of every bit inverted; the vote must reject it.
        apply_stimulus(0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_drain("pending_55");
        idle_ticks(20);

        // Reset mid-frame, four ticks into data bit 4.
        wait_tick();
        send_bit(0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            rx = 1'b1;
            wait_tick();
        end
        rst_n = 1'b0;
        rx    = 1'b1;
        #2;
        check_output("abort_rx_data", rx_data, 8'h00);
        check_output("abort_rx_valid", {7'b0, rx_valid}, 8'h00);
        check_output("abort_rx_data_b", rx_data_p, 8'h00);
        check_output("abort_parity_err_b", {7'b0, parity_err_p}, 8'h00);
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        idle_ticks(40);
        apply_stimulus(0, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_drain("pending_f0");
        idle_ticks(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
